// File: rtl/cpu_pkg.sv
// Shared CPU types: decoded control bundle, zero-register number, datapath width.
package cpu_pkg;
  localparam int DW = 64;
  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       set_flags;
    logic [2:0] alu_op;
  } ctrl_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, write-back port, and ID/EX outputs of the decode-to-execute stage.
interface id_ex_stage_if #(
  parameter int DW   = 64,
  parameter int CNTW = 16
) ();
  import cpu_pkg::*;

  logic            id_valid;
  logic [DW-1:0]   id_pc;
  logic [4:0]      id_rn, id_rm, id_rd;
  logic            id_uses_rn, id_uses_rm;
  logic [DW-1:0]   id_rd1, id_rd2;
  logic [DW-1:0]   id_imm;
  ctrl_t           id_ctrl;
  logic            wb_regwrite;
  logic [4:0]      wb_reg;
  logic [DW-1:0]   wb_data;
  logic            flush;

  logic            stall_out;
  logic            ex_valid;
  logic [DW-1:0]   ex_pc, ex_imm;
  logic [4:0]      ex_rn, ex_rm, ex_rd;
  logic [DW-1:0]   ex_a, ex_b;
  ctrl_t           ex_ctrl;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output id_valid, id_pc, id_rn, id_rm, id_rd, id_uses_rn, id_uses_rm,
           id_rd1, id_rd2, id_imm, id_ctrl, wb_regwrite, wb_reg, wb_data, flush,
    input  stall_out, ex_valid, ex_pc, ex_imm, ex_rn, ex_rm, ex_rd,
           ex_a, ex_b, ex_ctrl, stall_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rn, id_rm, id_rd, id_uses_rn, id_uses_rm,
           id_rd1, id_rd2, id_imm, id_ctrl, wb_regwrite, wb_reg, wb_data, flush,
    output stall_out, ex_valid, ex_pc, ex_imm, ex_rn, ex_rm, ex_rd,
           ex_a, ex_b, ex_ctrl, stall_cnt
  );
endinterface

// File: rtl/operand_bypass.sv
// One read port's operand select: X31 reads zero, else same-cycle WB bypass, else regfile data.
module operand_bypass #(
  parameter int DW = 64
) (
  input  logic [4:0]    i_reg,
  input  logic [DW-1:0] i_rf_data,
  input  logic          i_wb_we,
  input  logic [4:0]    i_wb_reg,
  input  logic [DW-1:0] i_wb_data,
  output logic [DW-1:0] o_data
);
  import cpu_pkg::*;

  // X31 check comes first so a write-back to X31 can never leak through.
  always_comb begin
    o_data = i_rf_data;
    if (i_reg == XZR)
      o_data = '0;
    else if (i_wb_we && (i_wb_reg == i_reg))
      o_data = i_wb_data;
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass, load-use bubble insertion and stall counter.
module id_ex_stage #(
  parameter int DW   = 64,
  parameter int CNTW = 16
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);
  import cpu_pkg::*;

  logic               r_valid;
  ctrl_t              r_ctrl;
  logic [DW-1:0]      r_pc, r_imm, r_a, r_b;
  logic [4:0]         r_rn, r_rm, r_rd;
  logic [CNTW-1:0]    r_cnt;

  logic [1:0][4:0]    w_sel;
  logic [1:0][DW-1:0] w_rf, w_op;
  logic               w_ld_in_ex, w_hazard, w_stall, w_load;

  // Port 0 is operand A (rn / ReadData1), port 1 is operand B (rm / ReadData2).
  assign w_sel = {bus.id_rm, bus.id_rn};
  assign w_rf  = {bus.id_rd2, bus.id_rd1};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_byp
      operand_bypass #(.DW(DW)) u_byp (
        .i_reg     (w_sel[g]),
        .i_rf_data (w_rf[g]),
        .i_wb_we   (bus.wb_regwrite),
        .i_wb_reg  (bus.wb_reg),
        .i_wb_data (bus.wb_data),
        .o_data    (w_op[g])
      );
    end
  endgenerate

  // A load to X31 produces nothing a consumer can depend on.
  assign w_ld_in_ex = r_valid && r_ctrl.mem_read && (r_rd != XZR);
  assign w_hazard   = w_ld_in_ex && bus.id_valid &&
                      ((bus.id_uses_rn && (r_rd == bus.id_rn)) ||
                       (bus.id_uses_rm && (r_rd == bus.id_rm)));
  // A flush redirects fetch anyway, so holding decode would only lose the redirect.
  assign w_stall    = w_hazard && !bus.flush;
  assign w_load     = !bus.flush && !w_hazard;

  // Valid/control: flush or hazard inserts a bubble, otherwise take the decode slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (bus.flush || w_hazard) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_valid <= bus.id_valid;
      r_ctrl  <= bus.id_valid ? bus.id_ctrl : ctrl_t'('0);
    end
  end

  // Data fields hold across bubbles and load only on a normal advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc  <= '0;
      r_imm <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_rn  <= '0;
      r_rm  <= '0;
      r_rd  <= '0;
    end else if (w_load) begin
      r_pc  <= bus.id_pc;
      r_imm <= bus.id_imm;
      r_a   <= w_op[0];
      r_b   <= w_op[1];
      r_rn  <= bus.id_rn;
      r_rm  <= bus.id_rm;
      r_rd  <= bus.id_rd;
    end
  end

  // Saturating count of cycles in which decode was held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cnt <= '0;
    else if (w_stall && (r_cnt != {CNTW{1'b1}}))
      r_cnt <= r_cnt + CNTW'(1);
  end

  assign bus.stall_out = w_stall;
  assign bus.ex_valid  = r_valid;
  assign bus.ex_ctrl   = r_ctrl;
  assign bus.ex_pc     = r_pc;
  assign bus.ex_imm    = r_imm;
  assign bus.ex_a      = r_a;
  assign bus.ex_b      = r_b;
  assign bus.ex_rn     = r_rn;
  assign bus.ex_rm     = r_rm;
  assign bus.ex_rd     = r_rd;
  assign bus.stall_cnt = r_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench: operand-select vector table plus load-use, flush, reset and saturation sequences.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  id_ex_stage_if #(.DW(64), .CNTW(16)) b ();
  id_ex_stage_if #(.DW(64), .CNTW(4))  s ();

  id_ex_stage #(.DW(64), .CNTW(16)) dut     (.clk(clk), .reset(rst_n), .bus(b.slave));
  id_ex_stage #(.DW(64), .CNTW(4))  dut_sat (.clk(clk), .reset(rst_n), .bus(s.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rn, rm;
    logic [63:0] rd1, rd2;
    logic        we;
    logic [4:0]  wreg;
    logic [63:0] wdata;
    logic [63:0] ea, eb;
  } vec_t;

  vec_t  tv [7];
  ctrl_t C_LD, C_ADD, c;
  logic  m_ld;
  int    m_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                          input logic [4:0] rd, input logic urn, input logic urm,
                          input ctrl_t ct, input logic [63:0] pc);
    b.id_valid   = v;
    b.id_rn      = rn;
    b.id_rm      = rm;
    b.id_rd      = rd;
    b.id_uses_rn = urn;
    b.id_uses_rm = urm;
    b.id_ctrl    = ct;
    b.id_pc      = pc;
  endtask

  initial begin
    C_LD  = ctrl_t'(9'b1_1_0_1_1_0_000);
    C_ADD = ctrl_t'(9'b1_0_0_0_0_0_010);
    tv[0] = '{5'd3,  5'd4,  64'h55,   64'h66, 1'b0, 5'd0,  64'h0,    64'h55,  64'h66};
    tv[1] = '{5'd31, 5'd2,  64'hDEAD, 64'h77, 1'b1, 5'd31, 64'hBEEF, 64'h0,   64'h77};
    tv[2] = '{5'd1,  5'd7,  64'h11,   64'h1,  1'b1, 5'd7,  64'hA0,   64'h11,  64'hA0};
    tv[3] = '{5'd1,  5'd7,  64'h11,   64'h1,  1'b0, 5'd7,  64'hA0,   64'h11,  64'h1};
    tv[4] = '{5'd9,  5'd9,  64'hAA,   64'hBB, 1'b1, 5'd9,  64'h123,  64'h123, 64'h123};
    tv[5] = '{5'd31, 5'd31, 64'hFF,   64'hEE, 1'b1, 5'd31, 64'h999,  64'h0,   64'h0};
    tv[6] = '{5'd9,  5'd10, 64'h12,   64'h34, 1'b1, 5'd8,  64'h777,  64'h12,  64'h34};

    rst_n = 1'b0;
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ctrl_t'('0), 64'h0);
    b.id_rd1 = '0; b.id_rd2 = '0; b.id_imm = '0;
    b.wb_regwrite = 1'b0; b.wb_reg = '0; b.wb_data = '0; b.flush = 1'b0;
    s.id_valid = 1'b0; s.id_pc = '0; s.id_rn = '0; s.id_rm = '0; s.id_rd = '0;
    s.id_uses_rn = 1'b0; s.id_uses_rm = 1'b0; s.id_rd1 = '0; s.id_rd2 = '0;
    s.id_imm = '0; s.id_ctrl = '0; s.wb_regwrite = 1'b0; s.wb_reg = '0;
    s.wb_data = '0; s.flush = 1'b0;

    #12;
    chk("rst_valid", 64'(b.ex_valid), 64'h0);
    chk("rst_ctrl",  64'(b.ex_ctrl),  64'h0);
    chk("rst_a",     b.ex_a,          64'h0);
    chk("rst_pc",    b.ex_pc,         64'h0);
    chk("rst_stall", 64'(b.stall_out), 64'h0);
    chk("rst_cnt",   64'(b.stall_cnt), 64'h0);
    rst_n = 1'b1;
    step();

    // Operand select table: no loads in flight, so no hazards.
    for (int i = 0; i < 7; i++) begin
      c = C_ADD;
      c.alu_op = 3'(i);
      drive_id(1'b1, tv[i].rn, tv[i].rm, 5'(10 + i), 1'b1, 1'b1, c, 64'h1000 + 64'(i * 4));
      b.id_rd1 = tv[i].rd1;
      b.id_rd2 = tv[i].rd2;
      b.id_imm = 64'(i * 3);
      b.wb_regwrite = tv[i].we;
      b.wb_reg  = tv[i].wreg;
      b.wb_data = tv[i].wdata;
      #1;
      chk($sformatf("v%0d_stall", i), 64'(b.stall_out), 64'h0);
      step();
      chk($sformatf("v%0d_a", i),     b.ex_a,            tv[i].ea);
      chk($sformatf("v%0d_b", i),     b.ex_b,            tv[i].eb);
      chk($sformatf("v%0d_valid", i), 64'(b.ex_valid),   64'h1);
      chk($sformatf("v%0d_ctrl", i),  64'(b.ex_ctrl),    64'(c));
      chk($sformatf("v%0d_pc", i),    b.ex_pc,           64'h1000 + 64'(i * 4));
      chk($sformatf("v%0d_imm", i),   b.ex_imm,          64'(i * 3));
      chk($sformatf("v%0d_rd", i),    64'(b.ex_rd),      64'(10 + i));
      chk($sformatf("v%0d_rn", i),    64'(b.ex_rn),      64'(tv[i].rn));
      chk($sformatf("v%0d_rm", i),    64'(b.ex_rm),      64'(tv[i].rm));
    end
    b.wb_regwrite = 1'b0;

    // Load-use on rn: one stall, one bubble, then the ADD advances.
    drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LD, 64'h2000);
    step();
    chk("lu_ld_rd", 64'(b.ex_rd), 64'h5);
    drive_id(1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, C_ADD, 64'h2004);
    #1;
    chk("lu_stall", 64'(b.stall_out), 64'h1);
    step();
    chk("lu_bub_valid", 64'(b.ex_valid),  64'h0);
    chk("lu_bub_ctrl",  64'(b.ex_ctrl),   64'h0);
    chk("lu_bub_rd",    64'(b.ex_rd),     64'h5);
    chk("lu_bub_pc",    b.ex_pc,          64'h2000);
    chk("lu_bub_stall", 64'(b.stall_out), 64'h0);
    chk("lu_bub_cnt",   64'(b.stall_cnt), 64'h1);
    step();
    chk("lu_add_valid", 64'(b.ex_valid),  64'h1);
    chk("lu_add_rd",    64'(b.ex_rd),     64'h6);
    chk("lu_add_ctrl",  64'(b.ex_ctrl),   64'(C_ADD));
    chk("lu_add_stall", 64'(b.stall_out), 64'h0);
    chk("lu_add_cnt",   64'(b.stall_cnt), 64'h1);

    // Flush with a pending load-use: no stall, bubble, data held, count unchanged.
    drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LD, 64'h3000);
    step();
    drive_id(1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, C_ADD, 64'h3004);
    b.flush = 1'b1;
    #1;
    chk("fl_stall", 64'(b.stall_out), 64'h0);
    step();
    b.flush = 1'b0;
    chk("fl_valid", 64'(b.ex_valid),  64'h0);
    chk("fl_ctrl",  64'(b.ex_ctrl),   64'h0);
    chk("fl_pc",    b.ex_pc,          64'h3000);
    chk("fl_cnt",   64'(b.stall_cnt), 64'h1);

    // id_valid=0 with matching registers: no hazard, empty slot loads.
    drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LD, 64'h4000);
    step();
    drive_id(1'b0, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, C_ADD, 64'h4004);
    #1;
    chk("iv_stall", 64'(b.stall_out), 64'h0);
    step();
    chk("iv_valid", 64'(b.ex_valid), 64'h0);
    chk("iv_ctrl",  64'(b.ex_ctrl),  64'h0);
    chk("iv_rd",    64'(b.ex_rd),    64'h6);

    // Load to X31 never creates a hazard.
    drive_id(1'b1, 5'd1, 5'd0, 5'd31, 1'b1, 1'b0, C_LD, 64'h5000);
    step();
    drive_id(1'b1, 5'd31, 5'd31, 5'd6, 1'b1, 1'b1, C_ADD, 64'h5004);
    #1;
    chk("x31_stall", 64'(b.stall_out), 64'h0);
    step();
    chk("x31_valid", 64'(b.ex_valid), 64'h1);

    // Matching rn that is not actually read: no hazard.
    drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LD, 64'h6000);
    step();
    drive_id(1'b1, 5'd5, 5'd2, 5'd6, 1'b0, 1'b1, C_ADD, 64'h6004);
    #1;
    chk("nouse_stall", 64'(b.stall_out), 64'h0);
    step();

    // Load-use through rm.
    drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LD, 64'h7000);
    step();
    drive_id(1'b1, 5'd2, 5'd5, 5'd6, 1'b1, 1'b1, C_ADD, 64'h7004);
    #1;
    chk("rm_stall", 64'(b.stall_out), 64'h1);
    step();
    chk("rm_cnt", 64'(b.stall_cnt), 64'h2);
    step();

    // Reset asserted mid-stall clears everything without a clock edge.
    drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LD, 64'h8000);
    step();
    drive_id(1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, C_ADD, 64'h8004);
    #1;
    chk("mr_stall_pre", 64'(b.stall_out), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(b.ex_valid),  64'h0);
    chk("mr_ctrl",  64'(b.ex_ctrl),   64'h0);
    chk("mr_stall", 64'(b.stall_out), 64'h0);
    chk("mr_cnt",   64'(b.stall_cnt), 64'h0);
    chk("mr_pc",    b.ex_pc,          64'h0);
    chk("mr_a",     b.ex_a,           64'h0);
    chk("mr_rd",    64'(b.ex_rd),     64'h0);
    #2 rst_n = 1'b1;
    step();
    chk("mr_post_valid", 64'(b.ex_valid), 64'h1);
    chk("mr_post_rd",    64'(b.ex_rd),    64'h6);
    chk("mr_post_ctrl",  64'(b.ex_ctrl),  64'(C_ADD));
    chk("mr_post_cnt",   64'(b.stall_cnt), 64'h0);

    // Saturation on the narrow-counter instance: a load reading its own
    // destination stalls every other cycle.
    s.id_valid = 1'b1; s.id_rn = 5'd5; s.id_uses_rn = 1'b1; s.id_rd = 5'd5;
    s.id_ctrl = C_LD;
    m_ld  = 1'b0;
    m_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("sat_stall_%0d", k), 64'(s.stall_out), 64'(m_ld));
      step();
      if (m_ld) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
      m_ld = !m_ld;
      chk($sformatf("sat_cnt_%0d", k), 64'(s.stall_cnt), 64'(m_cnt));
    end
    chk("sat_final", 64'(s.stall_cnt), 64'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
